data_memory_responder: RTL and testbench

Memory-side responder for the memory_port interface. It terminates the datapath's load/store requests with a word-organised RAM, byte-lane write masking and a small memory-mapped I/O window (cycle counter, debug register, fault status). Misaligned and unmapped accesses raise a sticky fault. It sits directly under the datapath's data-memory modport.

---
 rtl/memory_access_width.sv | 15 +
 rtl/memory_port.sv | 23 ++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/data_memory_responder.sv | 126 ++++++++++++
 tb/tb_data_memory_responder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_width.sv
// Shared access-width encoding and MMIO register offsets
// for the data-memory responder.
package memory_access_width;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_access_width_t;

  localparam logic [3:0] MMIO_CYCLE_OFF = 4'd0;
  localparam logic [3:0] MMIO_DEBUG_OFF = 4'd4;
  localparam logic [3:0] MMIO_FAULT_OFF = 4'd8;

endpackage

// File: rtl/memory_port.sv
// Datapath <-> data-memory request/response bundle.
// The memory side sees requests in and returns data_rd.
interface memory_port;
  import memory_access_width::*;

  logic                 valid;
  logic                 we;
  logic [31:0]          addr;
  memory_access_width_t width;
  logic [31:0]          data_wr;
  logic [31:0]          data_rd;

  modport memory (
    input  valid, we, addr, width, data_wr,
    output data_rd
  );

  modport datapath (
    output valid, we, addr, width, data_wr,
    input  data_rd
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane enables, write replication, read extraction and
// alignment check for one 32-bit word access.
//   in : addr[1:0], width, data_wr, raw RAM word
//   out: byte_en, wdata, rdata (zero-extended), misaligned
module mem_lane_align
  import memory_access_width::*;
(
  input  logic [1:0]           addr,
  input  memory_access_width_t width,
  input  logic [31:0]          data_wr,
  input  logic [31:0]          rword,
  output logic [3:0]           byte_en,
  output logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 misaligned
);

  logic [31:0] shifted;

  always_comb begin
    byte_en    = '0;
    wdata      = '0;
    rdata      = '0;
    misaligned = 1'b0;
    shifted    = rword >> {addr, 3'b000};
    case (width)
      BYTE: begin
        byte_en = 4'b0001 << addr;
        wdata   = {4{data_wr[7:0]}};
        rdata   = {24'b0, shifted[7:0]};
      end
      HALF: begin
        misaligned = addr[0];
        byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data_wr[15:0]}};
        rdata      = {16'b0, shifted[15:0]};
      end
      WORD: begin
        misaligned = |addr;
        byte_en    = 4'b1111;
        wdata      = data_wr;
        rdata      = rword;
      end
      // unused encoding is rejected as misaligned
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word RAM with byte lanes, MMIO window
// (cycle counter, debug reg, fault status) and sticky fault latch.
//   clk, reset (async high), port (memory modport),
//   fault, fault_addr, fault_misaligned, debug_out
module data_memory_responder
  import memory_access_width::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  memory_port.memory  port,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        fault_misaligned,
  output logic [31:0] debug_out
);

  localparam int AW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES =
    33'(MEM_WORDS) << 2;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]   cycle;
  logic [AW-1:0] widx;
  logic [3:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   ram_word;
  logic [31:0]   lane_rd;
  logic [31:0]   rd_data;
  logic          lane_mis;
  logic          in_ram;
  logic          in_mmio;
  logic          unmapped;
  logic          mis;
  logic          bad;
  logic          do_wr;

  assign widx     = port.addr[AW+1:2];
  assign off      = port.addr[3:0];
  assign ram_word = mem[widx];

  // RAM decode wins if the window overlaps it
  assign in_ram   = {1'b0, port.addr} < RAM_BYTES;
  assign in_mmio  = !in_ram &&
    (port.addr[31:4] == MMIO_BASE[31:4]);
  assign unmapped = !in_ram && !in_mmio;

  // MMIO registers only accept whole words
  assign mis   = lane_mis ||
    (in_mmio && port.width != WORD);
  assign bad   = port.valid && (mis || unmapped);
  assign do_wr = port.valid && port.we && !bad;

  mem_lane_align u_align (
    .addr       (port.addr[1:0]),
    .width      (port.width),
    .data_wr    (port.data_wr),
    .rword      (ram_word),
    .byte_en    (be),
    .wdata      (wdata),
    .rdata      (lane_rd),
    .misaligned (lane_mis)
  );

  always_comb begin
    rd_data = '0;
    if (port.valid && !port.we && !bad) begin
      if (in_ram) begin
        rd_data = lane_rd;
      end else begin
        case (off)
          MMIO_CYCLE_OFF: rd_data = cycle;
          MMIO_DEBUG_OFF: rd_data = debug_out;
          MMIO_FAULT_OFF:
            rd_data = {30'b0, fault_misaligned, fault};
          default:        rd_data = '0;
        endcase
      end
    end
  end

  assign port.data_rd = rd_data;

  // Contents are kept through reset; a write seen while
  // reset is high is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && do_wr && in_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle            <= '0;
      debug_out        <= '0;
      fault            <= 1'b0;
      fault_addr       <= '0;
      fault_misaligned <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (do_wr && in_mmio) begin
        if (off == MMIO_DEBUG_OFF) debug_out <= port.data_wr;
        if (off == MMIO_FAULT_OFF) begin
          fault            <= 1'b0;
          fault_addr       <= '0;
          fault_misaligned <= 1'b0;
        end
      end
      // first fault wins until software clears it
      if (bad && !fault) begin
        fault            <= 1'b1;
        fault_addr       <= port.addr;
        fault_misaligned <= mis;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: reads push
// expected values, a negedge monitor pops and compares.
module tb_data_memory_responder;
  import memory_access_width::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fault;
  logic [31:0] fault_addr;
  logic        fault_misaligned;
  logic [31:0] debug_out;

  memory_port mp ();

  data_memory_responder dut (
    .clk              (clk),
    .reset            (reset),
    .port             (mp),
    .fault            (fault),
    .fault_addr       (fault_addr),
    .fault_misaligned (fault_misaligned),
    .debug_out        (debug_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       n;
    logic [31:0] rd;
    logic        f;
    logic [31:0] fa;
    logic        fm;
    logic [31:0] dbg;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic        ef = 1'b0;
  logic [31:0] efa = '0;
  logic        efm = 1'b0;
  logic [31:0] edbg = '0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic clr_model();
    ef = 1'b0;
    efa = '0;
    efm = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input memory_access_width_t w,
                    input logic [31:0] d);
    mp.valid = 1'b1;
    mp.we = 1'b1;
    mp.addr = a;
    mp.width = w;
    mp.data_wr = d;
    @(posedge clk);
    #1;
    mp.valid = 1'b0;
    mp.we = 1'b0;
  endtask

  task automatic rd(input string n,
                    input logic [31:0] a,
                    input memory_access_width_t w,
                    input logic [31:0] d);
    exp_t e;
    mp.valid = 1'b1;
    mp.we = 1'b0;
    mp.addr = a;
    mp.width = w;
    mp.data_wr = 32'h0;
    e.n = n;
    e.rd = d;
    e.f = ef;
    e.fa = efa;
    e.fm = efm;
    e.dbg = edbg;
    q.push_back(e);
    @(posedge clk);
    #1;
    mp.valid = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mp.valid && !mp.we) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty addr=%h", mp.addr);
        end else begin
          e = q.pop_front();
          chk({e.n, "_rd"}, mp.data_rd, e.rd);
          chk({e.n, "_f"}, {31'b0, fault}, {31'b0, e.f});
          chk({e.n, "_fa"}, fault_addr, e.fa);
          chk({e.n, "_fm"}, {31'b0, fault_misaligned},
              {31'b0, e.fm});
          chk({e.n, "_dbg"}, debug_out, e.dbg);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    mp.valid = 1'b0;
    mp.we = 1'b0;
    mp.addr = '0;
    mp.width = WORD;
    mp.data_wr = '0;
    repeat (2) @(posedge clk);
    #1;
    rd("rst_cyc", MB, WORD, 32'h0);
    reset = 1'b0;
    rd("cyc0", MB, WORD, 32'h0);
    rd("cyc1", MB, WORD, 32'h1);

    wr(32'h10, WORD, 32'hDEADBEEF);
    wr(32'h11, BYTE, 32'h000000AA);
    rd("w10", 32'h10, WORD, 32'hDEADAAEF);
    rd("b13", 32'h13, BYTE, 32'h000000DE);
    rd("h12", 32'h12, HALF, 32'h0000DEAD);
    rd("b11", 32'h11, BYTE, 32'h000000AA);

    wr(32'h20, WORD, 32'h0);
    wr(32'h22, HALF, 32'hFFFF1234);
    rd("w20", 32'h20, WORD, 32'h12340000);
    rd("h22", 32'h22, HALF, 32'h00001234);
    rd("h20", 32'h20, HALF, 32'h0);

    wr(32'h04, WORD, 32'h01020304);
    wr(32'h06, WORD, 32'hFFFFFFFF);
    ef = 1'b1; efa = 32'h6; efm = 1'b1;
    rd("w04", 32'h04, WORD, 32'h01020304);
    rd("mis_h05", 32'h05, HALF, 32'h0);
    wr(32'h8000_0000, WORD, 32'h1);
    rd("fstat", MB + 8, WORD, 32'h3);

    wr(MB + 8, WORD, 32'h0);
    clr_model();
    rd("fclr", MB + 8, WORD, 32'h0);
    rd("unm_rd", 32'h8000_0000, WORD, 32'h0);
    ef = 1'b1; efa = 32'h8000_0000; efm = 1'b0;
    rd("fstat_unm", MB + 8, WORD, 32'h1);

    wr(MB + 8, WORD, 32'hFFFF_FFFF);
    clr_model();
    wr(32'hFFC, WORD, 32'hA5A5A5A5);
    rd("ram_top", 32'hFFC, WORD, 32'hA5A5A5A5);
    rd("ram_end", 32'h1000, BYTE, 32'h0);
    ef = 1'b1; efa = 32'h1000; efm = 1'b0;

    wr(MB + 8, WORD, 32'h0);
    clr_model();
    rd("mmio_b", MB + 4, BYTE, 32'h0);
    ef = 1'b1; efa = MB + 4; efm = 1'b1;
    wr(MB + 8, WORD, 32'h0);
    clr_model();

    wr(MB + 4, WORD, 32'h55);
    edbg = 32'h55;
    rd("dbg", MB + 4, WORD, 32'h55);
    wr(MB + 0, WORD, 32'h123);
    wr(MB + 12, WORD, 32'h456);
    rd("rsvd", MB + 12, WORD, 32'h0);

    wr(32'h30, WORD, 32'hCAFE0000);
    wr(32'h31, HALF, 32'h0);
    ef = 1'b1; efa = 32'h31; efm = 1'b1;
    rd("w30", 32'h30, WORD, 32'hCAFE0000);

    mp.valid = 1'b1;
    mp.we = 1'b1;
    mp.addr = 32'h30;
    mp.width = WORD;
    mp.data_wr = 32'h11111111;
    #2;
    reset = 1'b1;
    #1;
    chk("async_dbg", debug_out, 32'h0);
    chk("async_f", {31'b0, fault}, 32'h0);
    chk("async_fa", fault_addr, 32'h0);
    clr_model();
    edbg = 32'h0;
    @(posedge clk);
    #1;
    rd("rst_mid_cyc", MB, WORD, 32'h0);
    reset = 1'b0;
    rd("cyc_restart", MB, WORD, 32'h0);
    rd("no_commit", 32'h30, WORD, 32'hCAFE0000);

    repeat (2) @(posedge clk);
    chk("sb_drain", q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
